// File: rtl/axis_fifo.sv
// AXI-Stream FIFO: DEPTH-entry circular buffer with first-word-fall-through output
// and an optional packet mode that holds output until a whole packet is stored.

module axis_fifo_lane #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);
  // Storage is left uninitialised on reset; the pointers alone decide what is valid.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

module axis_fifo #(
  parameter int AXIS_BYTES  = 1,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                        clk,
  input  logic                        aresetn,
  output logic                        axis_i_tready,
  input  logic                        axis_i_tvalid,
  input  logic                        axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0]     axis_i_tdata,
  input  logic                        axis_o_tready,
  output logic                        axis_o_tvalid,
  output logic                        axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]     axis_o_tdata,
  output logic [$clog2(DEPTH):0]      fill_level,
  output logic [$clog2(DEPTH):0]      pkt_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW:0]       wr_ptr, rd_ptr, pkt_q;
  logic              rel_q, run_q;
  logic [DEPTH-1:0]  last_mem;
  logic              wr_fire, rd_fire, full, empty, head_last;
  logic              wr_last, rd_last;
  logic [AXIS_BYTES-1:0][7:0] wr_bytes, rd_bytes;

  // Pointers carry one extra MSB so full (MSBs differ) and empty (equal) are distinct.
  assign fill_level = wr_ptr - rd_ptr;
  assign full       = (fill_level == FULL);
  assign empty      = (fill_level == '0);
  assign pkt_count  = pkt_q;

  // run_q keeps tready low through reset and raises it on the first edge afterwards.
  assign axis_i_tready = run_q && !full;

  generate
    if (PACKET_MODE != 0) begin : g_pkt
      // Full with no complete packet means an oversize packet: cut it through.
      assign axis_o_tvalid = run_q && !empty && ((pkt_q != '0) || full || rel_q);
    end else begin : g_stream
      assign axis_o_tvalid = run_q && !empty;
    end
  endgenerate

  assign wr_fire   = axis_i_tvalid && axis_i_tready;
  assign rd_fire   = axis_o_tvalid && axis_o_tready;
  assign head_last = last_mem[rd_ptr[AW-1:0]];
  assign wr_last   = wr_fire && axis_i_tlast;
  assign rd_last   = rd_fire && head_last;

  assign wr_bytes     = axis_i_tdata;
  assign axis_o_tdata = rd_bytes;
  assign axis_o_tlast = head_last;

  generate
    for (genvar g = 0; g < AXIS_BYTES; g++) begin : g_lane
      axis_fifo_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_bytes[g]),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_bytes[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_fire) last_mem[wr_ptr[AW-1:0]] <= axis_i_tlast;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pkt_q  <= '0;
      rel_q  <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_last, rd_last})
        2'b10:   pkt_q <= pkt_q + 1'b1;
        2'b01:   pkt_q <= pkt_q - 1'b1;
        default: pkt_q <= pkt_q;
      endcase
      if (rd_last)                    rel_q <= 1'b0;
      else if (full && pkt_q == '0)   rel_q <= 1'b1;
    end
  end
endmodule
